// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared definitions for the instruction fetch unit.
//   ADDR_W_DEF   : default program address width
//   INSTR_W_DEF  : default instruction word width
//   RESET_PC_DEF : default first fetch address after reset
//   state_e      : fetch FSM states (IDLE, FETCH, HALT)
package fetch_pkg;

  localparam int          ADDR_W_DEF   = 8;
  localparam int          INSTR_W_DEF  = 17;
  localparam logic [7:0]  RESET_PC_DEF = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/fetch_pc.sv
// fetch_pc -- program counter register for the fetch unit.
// Branch load has priority over increment; the increment wraps modulo
// 2^ADDR_W through plain unsigned overflow.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load target into the PC this edge (branch)
//   target     : branch address
//   inc        : advance the PC by one this edge (fetch)
//   pc         : current program counter
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] target,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage with a single-entry instruction
// register (ir) handshaking to decode.
// Optional feature: define FETCH_PERF_CNT_EN to add the saturating
// fetch counter output fetch_cnt.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   run                : enables fetching
//   halt_req           : one-cycle request to stop fetching
//   br_valid/br_target : redirect the PC (highest priority, flushes ir)
//   pm_addr/pm_cs      : program memory address (= PC) and chip select
//   pm_instr           : combinational program memory read data
//   ir/ir_pc/ir_valid  : fetched instruction, its address, occupancy flag
//   ir_ready           : decode consumes ir this cycle
//   halted             : FSM is in HALT
//   fetch_cnt          : (FETCH_PERF_CNT_EN only) saturating fetch count
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               halt_req,
  input  logic               br_valid,
  input  logic [ADDR_W-1:0]  br_target,
  output logic [ADDR_W-1:0]  pm_addr,
  output logic               pm_cs,
  input  logic [INSTR_W-1:0] pm_instr,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic               halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        fetch_cnt
`endif
);

  state_e            state;
  state_e            state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              slot_free;
  logic              fetch;

  // The ir slot can take a new word when empty or being drained this cycle.
  assign slot_free = !ir_valid || ir_ready;
  // A branch always wins; halt_req suppresses the fetch in its own cycle.
  assign fetch     = (state == FETCH) && run && !halt_req && !br_valid && slot_free;
  assign pm_addr   = pc;

  fetch_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (br_valid),
    .target (br_target),
    .inc    (fetch),
    .pc     (pc)
  );

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (run) state_nxt = FETCH;
      FETCH: begin
        // A halt request wins over run dropping, also when paired with a branch.
        if (halt_req)  state_nxt = HALT;
        else if (!run) state_nxt = IDLE;
      end
      HALT:    if (!run) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // pm_cs and halted are registered alongside the state so they come
  // straight from flops with no decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pm_cs  <= 1'b0;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      pm_cs  <= (state_nxt == FETCH);
      halted <= (state_nxt == HALT);
    end
  end

  // NOTE: ir is a datapath register that would not normally need a reset,
  // but decode observes ir/ir_pc directly so they come up at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else if (br_valid) begin
      ir_valid <= 1'b0;
    end else if (fetch) begin
      ir       <= pm_instr;
      ir_pc    <= pc;
      ir_valid <= 1'b1;
    end else if (ir_valid && ir_ready) begin
      ir_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
    end else if (fetch && (fetch_cnt != 16'hFFFF)) begin
      fetch_cnt <= fetch_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit: directed vector
// table, hand-written corner sequences and randomized stimulus compared
// against a behavioural model. Define FETCH_PERF_CNT_EN to also cover
// fetch_cnt.
module tb_fetch_unit;

  localparam int S_IDLE  = 0;
  localparam int S_FETCH = 1;
  localparam int S_HALT  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        halt_req;
  logic        br_valid;
  logic [7:0]  br_target;
  logic [7:0]  pm_addr;
  logic        pm_cs;
  logic [16:0] pm_instr;
  logic [16:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt;
`endif

  logic [16:0] mem [256];
  assign pm_instr = mem[pm_addr];

  fetch_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .halt_req  (halt_req),
    .br_valid  (br_valid),
    .br_target (br_target),
    .pm_addr   (pm_addr),
    .pm_cs     (pm_cs),
    .pm_instr  (pm_instr),
    .ir        (ir),
    .ir_pc     (ir_pc),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .halted    (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt (fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: plain integers following the stated rules.
  int m_st;
  int m_pc;
  int m_ir;
  int m_ir_pc;
  int m_valid;
  int m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_pc = 0; m_ir = 0; m_ir_pc = 0; m_valid = 0; m_cnt = 0;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".pm_addr"},  32'(pm_addr),  32'(m_pc));
    check({tag, ".pm_cs"},    32'(pm_cs),    32'(m_st == S_FETCH));
    check({tag, ".halted"},   32'(halted),   32'(m_st == S_HALT));
    check({tag, ".ir_valid"}, 32'(ir_valid), 32'(m_valid));
    check({tag, ".ir_pc"},    32'(ir_pc),    32'(m_ir_pc));
    check({tag, ".ir"},       32'(ir),       32'(m_ir));
`ifdef FETCH_PERF_CNT_EN
    check({tag, ".fetch_cnt"}, 32'(fetch_cnt), 32'(m_cnt));
`endif
  endtask

  // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic r, input logic h, input logic b,
                      input logic [7:0] t, input logic rd, input string tag);
    bit fetch_now;
    int n_st;
    run = r; halt_req = h; br_valid = b; br_target = t; ir_ready = rd;
    fetch_now = (m_st == S_FETCH) && r && !h && !b && (m_valid == 0 || rd);
    n_st = m_st;
    if (m_st == S_IDLE && r) n_st = S_FETCH;
    else if (m_st == S_FETCH && h) n_st = S_HALT;
    else if (m_st == S_FETCH && !r) n_st = S_IDLE;
    else if (m_st == S_HALT && !r) n_st = S_IDLE;
    @(posedge clk);
    #1;
    if (b) begin
      m_pc = int'(t);
      m_valid = 0;
    end else if (fetch_now) begin
      m_ir = int'(mem[m_pc]);
      m_ir_pc = m_pc;
      m_valid = 1;
      m_pc = (m_pc + 1) % 256;
    end else if (m_valid == 1 && rd) begin
      m_valid = 0;
    end
    if (fetch_now && m_cnt < 65535) m_cnt++;
    m_st = n_st;
    compare_model(tag);
  endtask

  task automatic do_reset();
    run = 1'b0; halt_req = 1'b0; br_valid = 1'b0; br_target = 8'h00; ir_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #12;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  typedef struct {
    logic       run;
    logic       halt;
    logic       br;
    logic [7:0] tgt;
    logic       rdy;
    logic [7:0] e_addr;
    logic       e_cs;
    logic [7:0] e_ir_pc;
    logic       e_valid;
    logic       e_halted;
  } vec_t;

  vec_t tbl [16];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 17'($urandom);
    rst_n = 1'b1;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 8'h03, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h05, 1'b1, 8'h04, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h05, 1'b1, 8'h04, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h05, 1'b1, 8'h04, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h05, 1'b1, 8'h04, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h06, 1'b1, 8'h05, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h07, 1'b1, 8'h06, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 8'h20, 1'b1, 8'h20, 1'b1, 8'h06, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h21, 1'b1, 8'h20, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h21, 1'b0, 8'h20, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h21, 1'b0, 8'h20, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h21, 1'b0, 8'h20, 1'b0, 1'b0};

    // Reset values.
    do_reset();
    check("reset.pm_addr",  32'(pm_addr),  32'h00);
    check("reset.pm_cs",    32'(pm_cs),    32'h0);
    check("reset.ir",       32'(ir),       32'h0);
    check("reset.ir_pc",    32'(ir_pc),    32'h0);
    check("reset.ir_valid", 32'(ir_valid), 32'h0);
    check("reset.halted",   32'(halted),   32'h0);

    // Directed table: sequential fetch, stall, branch, halt, return to idle.
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].run, tbl[i].halt, tbl[i].br, tbl[i].tgt, tbl[i].rdy, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d.pm_addr", i),  32'(pm_addr),  32'(tbl[i].e_addr));
      check($sformatf("tbl%0d.pm_cs", i),    32'(pm_cs),    32'(tbl[i].e_cs));
      check($sformatf("tbl%0d.ir_pc", i),    32'(ir_pc),    32'(tbl[i].e_ir_pc));
      check($sformatf("tbl%0d.ir_valid", i), 32'(ir_valid), 32'(tbl[i].e_valid));
      check($sformatf("tbl%0d.halted", i),   32'(halted),   32'(tbl[i].e_halted));
      if (tbl[i].e_valid) check($sformatf("tbl%0d.ir", i), 32'(ir), 32'(mem[tbl[i].e_ir_pc]));
    end

    // PC wrap from FF to 00 with back-to-back fetches.
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, "wrap.go");
    step(1'b1, 1'b0, 1'b1, 8'hFE, 1'b1, "wrap.br");
    check("wrap.br_addr", 32'(pm_addr), 32'hFE);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, "wrap.f0");
    check("wrap.ir_pc_fe", 32'(ir_pc), 32'hFE);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, "wrap.f1");
    check("wrap.ir_pc_ff", 32'(ir_pc), 32'hFF);
    check("wrap.addr_00",  32'(pm_addr), 32'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, "wrap.f2");
    check("wrap.ir_pc_00", 32'(ir_pc), 32'h00);
    check("wrap.valid",    32'(ir_valid), 32'h1);
    check("wrap.addr_01",  32'(pm_addr), 32'h01);

    // Asynchronous reset in the middle of a stall.
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "stall.0");
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "stall.1");
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.pm_addr",  32'(pm_addr),  32'h00);
    check("midrst.pm_cs",    32'(pm_cs),    32'h0);
    check("midrst.ir",       32'(ir),       32'h0);
    check("midrst.ir_pc",    32'(ir_pc),    32'h0);
    check("midrst.ir_valid", 32'(ir_valid), 32'h0);
    check("midrst.halted",   32'(halted),   32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // First fetch after reset reads RESET_PC only once run is seen.
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "post.idle");
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, "post.go");
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, "post.f0");
    check("post.first_ir_pc", 32'(ir_pc), 32'h00);
    check("post.first_ir",    32'(ir),    32'(mem[0]));

    // Halt combined with branch: branch PC loads, FSM enters HALT.
    step(1'b1, 1'b1, 1'b1, 8'h40, 1'b0, "hb");
    check("hb.halted",  32'(halted),  32'h1);
    check("hb.pm_addr", 32'(pm_addr), 32'h40);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "hb.hold");
    check("hb.hold_addr", 32'(pm_addr), 32'h40);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "hb.idle");
    check("hb.idle_halted", 32'(halted), 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(logic'($urandom_range(0, 15) != 0), logic'($urandom_range(0, 31) == 0),
           logic'($urandom_range(0, 15) == 0), 8'($urandom),
           logic'($urandom_range(0, 3) != 0), "rnd");
    end

`ifdef FETCH_PERF_CNT_EN
    do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, "cnt.go");
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, "cnt");
    check("cnt.ten", 32'(fetch_cnt), 32'd10);
    do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, "sat.go");
    for (int i = 0; i < 65540; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, "sat");
    check("cnt.saturate", 32'(fetch_cnt), 32'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
